// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: commit-point and fetch-redirect bundle for exc_ctrl.
//
// Signals
//   m_valid, m_exc_valid, m_exccode, m_eret, m_pc, m_bd, m_badvaddr
//       commit-stage instruction presented to the sequencer
//   m_ready
//       commit accepted this cycle (sequencer idle)
//   redir_valid, redir_pc, redir_ready
//       fetch redirect handshake (sequencer -> fetch)
//
// Modports
//   master : commit/fetch side (drives m_*, redir_ready)
//   slave  : exc_ctrl
interface exc_ctrl_if;
  logic        m_valid;
  logic        m_exc_valid;
  logic [4:0]  m_exccode;
  logic        m_eret;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] m_badvaddr;
  logic        m_ready;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;

  modport master (
    output m_valid, m_exc_valid, m_exccode, m_eret, m_pc, m_bd, m_badvaddr,
    output redir_ready,
    input  m_ready, redir_valid, redir_pc
  );

  modport slave (
    input  m_valid, m_exc_valid, m_exccode, m_eret, m_pc, m_bd, m_badvaddr,
    input  redir_ready,
    output m_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-point exception / interrupt / ERET sequencer.
//
// Decides per cycle whether the committing instruction traps, erets or is
// interrupted, drives the cp0 exception inputs for that one cycle, then
// sequences a one-cycle flush followed by a fetch redirect handshake.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   commit            exc_ctrl_if.slave: commit instruction + redirect handshake
//   cause_ip, status_im, status_ie, status_exl, epc
//                     state read back from cp0
//   cp0_exception, cp0_exccode, cp0_pc, cp0_is_delay_slot, cp0_badvaddr
//                     cp0 exception inputs (valid only while cp0_exception=1)
//   flush             one-cycle kill of younger pipeline stages
//
// Parameters
//   VECTOR     exception entry PC
//   ERET_CODE  ERET pseudo-exccode understood by cp0
//
// Build option
//   EXC_CTRL_INT_EN  defined: interrupts are taken.
//                    undefined: interrupt inputs are ignored, only
//                    instruction exceptions and ERET trigger.
module exc_ctrl #(
  parameter logic [31:0] VECTOR    = 32'hBFC00380,
  parameter logic [4:0]  ERET_CODE = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  exc_ctrl_if.slave   commit,
  input  logic [7:0]  cause_ip,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] epc,
  output logic        cp0_exception,
  output logic [4:0]  cp0_exccode,
  output logic [31:0] cp0_pc,
  output logic        cp0_is_delay_slot,
  output logic [31:0] cp0_badvaddr,
  output logic        flush
);

  typedef enum logic [1:0] {RUN, FLUSH, REDIRECT} state_t;

  state_t      state_reg;
  logic        flush_reg;
  logic        redir_valid_reg;
  logic        m_ready_reg;
  logic [31:0] redir_pc_reg;
  logic        int_pend_q;
  logic        trig;
  logic        take_eret;
  logic [31:0] target;

`ifdef EXC_CTRL_INT_EN
  // Registered so the pending decision never depends combinationally on
  // cp0 outputs in the same cycle; costs one cycle of interrupt latency.
  always_ff @(posedge clk) begin
    if (reset)
      int_pend_q <= 1'b0;
    else
      int_pend_q <= status_ie & ~status_exl & (|(cause_ip & status_im));
  end
`else
  assign int_pend_q = 1'b0;
  logic unused_int_inputs;
  assign unused_int_inputs = ^{cause_ip, status_im, status_ie, status_exl};
`endif

  // Bubbles never trigger, so a pending interrupt waits for a real instruction.
  assign trig = (state_reg == RUN) & commit.m_valid &
                (int_pend_q | commit.m_exc_valid | commit.m_eret);

  // ERET only wins when neither an interrupt nor an instruction exception
  // is present on the same instruction.
  assign take_eret = ~int_pend_q & ~commit.m_exc_valid & commit.m_eret;
  assign target    = take_eret ? epc : VECTOR;

  // Mealy cp0 strobe: cp0 must see the exception in the trigger cycle itself.
  always_comb begin
    cp0_exception     = 1'b0;
    cp0_exccode       = 5'd0;
    cp0_pc            = 32'd0;
    cp0_is_delay_slot = 1'b0;
    cp0_badvaddr      = 32'd0;
    if (trig) begin
      cp0_exception     = 1'b1;
      cp0_pc            = commit.m_pc;
      cp0_is_delay_slot = commit.m_bd;
      cp0_badvaddr      = commit.m_badvaddr;
      if (int_pend_q)
        cp0_exccode = 5'd0;
      else if (commit.m_exc_valid)
        cp0_exccode = commit.m_exccode;
      else
        cp0_exccode = ERET_CODE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      flush_reg       <= 1'b0;
      redir_valid_reg <= 1'b0;
      m_ready_reg     <= 1'b1;
      redir_pc_reg    <= 32'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (trig) begin
            state_reg    <= FLUSH;
            flush_reg    <= 1'b1;
            m_ready_reg  <= 1'b0;
            redir_pc_reg <= target;
          end
        end
        FLUSH: begin
          state_reg       <= REDIRECT;
          flush_reg       <= 1'b0;
          redir_valid_reg <= 1'b1;
        end
        REDIRECT: begin
          if (commit.redir_ready) begin
            state_reg       <= RUN;
            redir_valid_reg <= 1'b0;
            m_ready_reg     <= 1'b1;
          end
        end
        default: begin
          state_reg       <= RUN;
          flush_reg       <= 1'b0;
          redir_valid_reg <= 1'b0;
          m_ready_reg     <= 1'b1;
        end
      endcase
    end
  end

  assign flush              = flush_reg;
  assign commit.redir_valid = redir_valid_reg;
  assign commit.redir_pc    = redir_pc_reg;
  assign commit.m_ready     = m_ready_reg;

endmodule
